gray_counter: RTL and testbench
===============================

# gray_counter

Registered binary/Gray up-down counter: the encoding side of the team's Gray code converters. Holds a binary count and, on every clock, drives the matching reflected-binary Gray code from the same flop stage. Intended for FIFO read/write pointers and position counters whose Gray output crosses to other logic. Downstream, `gray_to_binary` recovers the count.

## Interface
- `WIDTH`, default 4: counter and code width in bits. Must be at least 2.

Ports:
- `clk`: input, 1 bit. Rising-edge clock; the only clock.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `en`: input, 1 bit. Count enable. When high, the count advances one step per clock.
- `up`: input, 1 bit. Direction. 1 = increment, 0 = decrement. Sampled only when `en` = 1.
- `load`: input, 1 bit. Synchronous load of `load_bin`.
- `load_bin`: input, WIDTH bits. Binary value to load.
- `bin`: output, WIDTH bits. Registered binary count.
- `gray`: output, WIDTH bits. Registered Gray code of `bin`.
- `tc`: output, 1 bit. Registered terminal-count/wrap flag.

## Operation
- Next-state priority, evaluated at each rising `clk`: `rst` > `load` > `en` > hold.
- `rst` = 1:
  - `bin` <= 0, `gray` <= 0, `tc` <= 0.
  - `load`, `en` and `up` are ignored.
- `load` = 1 (and `rst` = 0):
  - `bin` <= `load_bin`.
  - `gray` <= `load_bin ^ (load_bin >> 1)`.
  - `tc` <= 0.
  - `en` is ignored; no step happens in the same cycle.
- `en` = 1 (and `rst` = 0, `load` = 0):
  - `nxt` = `bin + 1` if `up` = 1, else `bin - 1`.
  - Arithmetic is modulo 2^WIDTH with no saturation.
  - `bin` <= `nxt`; `gray` <= `nxt ^ (nxt >> 1)`.
- Hold (`en` = 0): `bin` and `gray` keep their values; `tc` <= 0.
- Gray is computed from the next binary value and registered in the same cycle. It is never derived combinationally from the `bin` flops, so `gray` and `bin` always describe the same count in every cycle.
- Wrap rules:
  - Up-count from all-ones to 0: `tc` <= 1.
  - Down-count from 0 to all-ones: `tc` <= 1.
  - Any other step: `tc` <= 0.
- `tc` is a single-cycle pulse per wrap. With `en` held high through several wraps it pulses once every 2^WIDTH steps.
- Invariants:
  - Two consecutive counting steps change exactly one `gray` bit, including at wrap and at a direction change.
  - Load and reset are exempt from this one-bit rule.
- Direction change: `up` may toggle on any cycle. The next step uses the new direction with no bubble.

## Timing
- Every output is a flop; there is no combinational path from any input to any output.
- Latency is one cycle. Inputs sampled at edge N appear on `bin`, `gray` and `tc` after edge N.
- Reset values: `bin` = 0, `gray` = 0, `tc` = 0. All are valid from the first edge at which `rst` is sampled high.
- Reset asserted mid-count takes effect at the next edge regardless of `load` or `en`. A pending wrap pulse is suppressed.
- Counting resumes on the first edge with `rst` = 0 and `en` = 1. From reset, the first up-step gives `bin` = 1, `gray` = 0001.
- Throughput: one step per clock while `en` is high.

## Test plan
- **Reset, then 16 up-steps (WIDTH = 4).**
  - `gray` must follow 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
  - `tc` = 1 only in the cycle where `bin` becomes 0000 (after `bin` = 1111 / `gray` = 1000).
  - Each step changes exactly one `gray` bit.
- **Down-wrap.**
  - Reset, then `en` = 1, `up` = 0 → `bin` = 1111, `gray` = 1000, `tc` = 1.
  - Next step → `bin` = 1110, `gray` = 1001, `tc` = 0.
- **Load.**
  - `load` = 1 with `load_bin` = 1010 → next cycle `bin` = 1010, `gray` = 1111, `tc` = 0.
  - `load` = 1 and `en` = 1 together with `load_bin` = 0110 → `bin` = 0110, `gray` = 0101, with no extra increment.
- **Reset priority.**
  - With `bin` = 1111, `en` = 1, `up` = 1: assert `rst` together with `load` (`load_bin` = 0011) → `bin` = 0000, `gray` = 0000, `tc` = 0.
  - The wrap pulse is suppressed.
- **Hold and direction change.**
  - From `bin` = 0101, drop `en` for 3 cycles → outputs unchanged and `tc` = 0.
  - Then up, up, down, down → `bin` sequence 0110, 0111, 0110, 0101, with single-bit `gray` changes throughout.
- **Round trip, WIDTH = 4 and WIDTH = 8.**
  - Feed `gray` into `gray_to_binary` for 2^WIDTH + 5 random-direction steps.
  - The decoded value must equal `bin` every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// Registered binary/Gray up-down counter. Binary and Gray outputs come from the
// same flop stage, so they always describe the same count.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             tc
);

   logic [WIDTH-1:0] bin_q,  bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             tc_q,   tc_d;
   logic [WIDTH-1:0] nxt;

   // NOTE: combinational blocks use blocking '=' with every output defaulted
   // first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      tc_d   = 1'b0;
      nxt    = up ? (bin_q + 1'b1) : (bin_q - 1'b1);

      if (load) begin
         bin_d  = load_bin;
         gray_d = load_bin ^ (load_bin >> 1);
      end else if (en) begin
         bin_d  = nxt;
         // Gray is encoded from the next binary value, never from the bin flops.
         gray_d = nxt ^ (nxt >> 1);
         tc_d   = up ? (bin_q == '1) : (bin_q == '0);
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         tc_q   <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         tc_q   <= tc_d;
      end
   end

   assign bin  = bin_q;
   assign gray = gray_q;
   assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH = 4 and WIDTH = 8: directed
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [7:0] lb = '0;

   logic [3:0] bin4, gray4;
   logic       tc4;
   logic [7:0] bin8, gray8;
   logic       tc8;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: plain integer counts, modulo 2^WIDTH.
   int m4_bin = 0, m4_tc = 0;
   int m8_bin = 0, m8_tc = 0;

   logic [3:0] gray_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   gray_counter #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_bin(lb[3:0]), .bin(bin4), .gray(gray4), .tc(tc4)
   );

   gray_counter #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_bin(lb), .bin(bin8), .gray(gray8), .tc(tc8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic int bin_of_gray(input int g, input int w);
      int b = 0;
      for (int s = 0; s < w; s++) b ^= g >> s;
      return b;
   endfunction

   task automatic model_step(inout int b, inout int t, input int m);
      if (rst) begin
         b = 0; t = 0;
      end else if (load) begin
         b = lb % m; t = 0;
      end else if (en) begin
         if (up) begin
            t = (b == m - 1) ? 1 : 0;
            b = (b + 1) % m;
         end else begin
            t = (b == 0) ? 1 : 0;
            b = (b + m - 1) % m;
         end
      end else begin
         t = 0;
      end
   endtask

   // One clock with the given controls; compares both DUTs against the model.
   task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                      input logic [7:0] ld);
      logic [3:0] prev4;
      logic [7:0] prev8;
      logic       counting;
      rst = r; load = l; en = e; up = u; lb = ld;
      prev4 = gray4;
      prev8 = gray8;
      counting = !r && !l && e;
      @(posedge clk);
      #1;
      model_step(m4_bin, m4_tc, 16);
      model_step(m8_bin, m8_tc, 256);
      check("bin4",  32'(bin4),  32'(m4_bin));
      check("gray4", 32'(gray4), 32'(gray_of(m4_bin)));
      check("tc4",   32'(tc4),   32'(m4_tc));
      check("bin8",  32'(bin8),  32'(m8_bin));
      check("gray8", 32'(gray8), 32'(gray_of(m8_bin)));
      check("tc8",   32'(tc8),   32'(m8_tc));
      check("roundtrip4", 32'(bin_of_gray(int'(gray4), 4)), 32'(bin4));
      check("roundtrip8", 32'(bin_of_gray(int'(gray8), 8)), 32'(bin8));
      if (counting) begin
         check("onebit4", 32'($countones(gray4 ^ prev4)), 32'd1);
         check("onebit8", 32'($countones(gray8 ^ prev8)), 32'd1);
      end
   endtask

   initial begin
      // Reset, then 16 up-steps through the full Gray sequence.
      cyc(1, 0, 0, 0, 8'h00);
      check("rst_gray", 32'(gray4), 32'd0);
      for (int k = 1; k <= 16; k++) begin
         cyc(0, 0, 1, 1, 8'h00);
         check("seq_gray", 32'(gray4), 32'(gray_seq[k % 16]));
         check("seq_tc",   32'(tc4),   (k == 16) ? 32'd1 : 32'd0);
      end

      // Down-wrap out of reset.
      cyc(1, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 8'h00);
      check("dwrap_bin",  32'(bin4),  32'hF);
      check("dwrap_gray", 32'(gray4), 32'h8);
      check("dwrap_tc",   32'(tc4),   32'd1);
      cyc(0, 0, 1, 0, 8'h00);
      check("dwrap2_bin",  32'(bin4),  32'hE);
      check("dwrap2_gray", 32'(gray4), 32'h9);
      check("dwrap2_tc",   32'(tc4),   32'd0);

      // Load, and load beating enable.
      cyc(0, 1, 0, 0, 8'h0A);
      check("load_bin",  32'(bin4),  32'hA);
      check("load_gray", 32'(gray4), 32'hF);
      check("load_tc",   32'(tc4),   32'd0);
      cyc(0, 1, 1, 1, 8'h06);
      check("loaden_bin",  32'(bin4),  32'h6);
      check("loaden_gray", 32'(gray4), 32'h5);

      // Reset beats load and suppresses a pending wrap.
      cyc(0, 1, 0, 0, 8'h0F);
      cyc(1, 1, 1, 1, 8'h03);
      check("rstpri_bin",  32'(bin4),  32'd0);
      check("rstpri_gray", 32'(gray4), 32'd0);
      check("rstpri_tc",   32'(tc4),   32'd0);

      // Hold for 3 cycles, then up, up, down, down.
      cyc(0, 1, 0, 0, 8'h05);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 8'h00);
         check("hold_bin",  32'(bin4),  32'h5);
         check("hold_gray", 32'(gray4), 32'h7);
         check("hold_tc",   32'(tc4),   32'd0);
      end
      cyc(0, 0, 1, 1, 8'h00); check("dir_bin", 32'(bin4), 32'h6);
      cyc(0, 0, 1, 1, 8'h00); check("dir_bin", 32'(bin4), 32'h7);
      cyc(0, 0, 1, 0, 8'h00); check("dir_bin", 32'(bin4), 32'h6);
      cyc(0, 0, 1, 0, 8'h00); check("dir_bin", 32'(bin4), 32'h5);

      // Randomized traffic: mostly counting, occasional load/hold/reset.
      cyc(1, 0, 0, 0, 8'h00);
      for (int k = 0; k < 600; k++) begin
         int sel;
         sel = $urandom_range(0, 99);
         cyc(sel == 0, (sel >= 1) && (sel <= 3), sel >= 8, 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      end

      // Long uninterrupted up run so the 8-bit counter wraps at least once.
      for (int k = 0; k < 261; k++) cyc(0, 0, 1, 1, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
